// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Multi-cycle WIDTH-bit adder built around a single four_bit_full_adder.
// Operands are accepted over a valid/ready handshake. The 4-bit adder then
// processes one nibble per cycle, least significant nibble first, and the
// carry is registered between nibbles. The assembled result is offered
// downstream over a second valid/ready handshake.
//
// Optional feature: define NIBBLE_SERIAL_ADDER_OVF_EN to add the 'ovf' output.
// 'ovf' is the two's-complement signed overflow of the add.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   in_valid  in   operands valid
//   in_ready  out  block can accept operands (registered, high only in IDLE)
//   a, b      in   WIDTH-bit operands
//   cin       in   carry into nibble 0
//   out_valid out  result valid (registered, high only in DONE)
//   out_ready in   downstream accepts result
//   sum       out  a+b+cin mod 2^WIDTH
//   cout      out  carry out of the MSB
//   ovf       out  signed overflow (only with NIBBLE_SERIAL_ADDER_OVF_EN)
//   busy      out  high while nibbles are being added
// -----------------------------------------------------------------------------

// Plain 4-bit adder with carry in/out; the only combinational datapath.
module four_bit_full_adder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [4:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
  assign o_sum  = w_full[3:0];
  assign o_cout = w_full[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NIB - 1);
  localparam logic [WIDTH-1:0] NIB_MASK  = WIDTH'(4'hF);

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_chk
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADD  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t            r_state,    w_state_nxt;
  logic [IDX_W-1:0]  r_idx,      w_idx_nxt;
  logic              r_carry,    w_carry_nxt;
  logic [WIDTH-1:0]  r_a,        w_a_nxt;
  logic [WIDTH-1:0]  r_b,        w_b_nxt;
  logic [WIDTH-1:0]  r_sum,      w_sum_nxt;
  logic              r_cout,     w_cout_nxt;
  logic              r_in_ready, w_in_ready_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_busy,     w_busy_nxt;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic              r_ovf,      w_ovf_nxt;
  logic              w_msb_cin;
`endif

  logic [IDX_W+1:0]  w_shamt;
  logic [WIDTH-1:0]  w_a_sh;
  logic [WIDTH-1:0]  w_b_sh;
  logic [3:0]        w_a_nib;
  logic [3:0]        w_b_nib;
  logic [3:0]        w_add_sum;
  logic              w_add_cout;

  // Nibble selection: shift the operand registers down by 4*idx.
  assign w_shamt = {r_idx, 2'b00};
  assign w_a_sh  = r_a >> w_shamt;
  assign w_b_sh  = r_b >> w_shamt;
  assign w_a_nib = w_a_sh[3:0];
  assign w_b_nib = w_b_sh[3:0];

  four_bit_full_adder u_fa4 (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  // Recover the carry into bit 3 of the final nibble from that bit's sum.
  assign w_msb_cin = w_a_nib[3] ^ w_b_nib[3] ^ w_add_sum[3];
`endif

  // Next-state and next-output computation for the whole block.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_carry_nxt = r_carry;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_sum_nxt   = r_sum;
    w_cout_nxt  = r_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    w_ovf_nxt   = r_ovf;
`endif

    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_a_nxt     = a;
          w_b_nxt     = b;
          w_carry_nxt = cin;
          w_idx_nxt   = {IDX_W{1'b0}};
          w_sum_nxt   = {WIDTH{1'b0}};
          w_state_nxt = S_ADD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ADD: begin
        // Overwrite only the nibble currently being processed.
        w_sum_nxt   = (r_sum & ~(NIB_MASK << w_shamt)) |
                      (WIDTH'(w_add_sum) << w_shamt);
        w_carry_nxt = w_add_cout;
        if (r_idx == LAST_IDX) begin
          w_cout_nxt  = w_add_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          w_ovf_nxt   = w_msb_cin ^ w_add_cout;
`endif
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Handshake/status outputs are registered copies of the next state.
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_busy_nxt      = (w_state_nxt == S_ADD);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= {IDX_W{1'b0}};
      r_carry     <= 1'b0;
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_sum       <= {WIDTH{1'b0}};
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_carry     <= w_carry_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_sum       <= w_sum_nxt;
      r_cout      <= w_cout_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      r_ovf       <= w_ovf_nxt;
`endif
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign busy      = r_busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder that sits directly upstream of, and wraps, one four_bit_full_adder instance.
- Accepts full-width operands over a valid/ready handshake and feeds the 4-bit adder one nibble per cycle, LSB nibble first.
- Registers the carry between nibbles.
- Assembles the result and presents it downstream over a valid/ready handshake.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4; any other value is an elaboration error ($error).
- NIB, WIDTH/4, derived localparam: number of nibbles and ADD-state cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into nibble 0
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result, a+b+cin mod 2^WIDTH
- cout  output  1  carry out of the MSB nibble
- busy  output  1  high in ADD state

Behaviour:
- Reset (async, rst=1): state=IDLE, nibble index=0, carry reg=0, operand regs=0, sum=0, cout=0, out_valid=0, busy=0, in_ready=1 once rst deasserts. Reset mid-ADD or mid-DONE aborts the operation; the partial result is discarded.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b; carry reg<=cin; index<=0; sum<=0; go to ADD.
- ADD:
  - in_ready=0, busy=1.
  - Each cycle, adder inputs are a_reg[4*idx+:4], b_reg[4*idx+:4] and carry reg.
  - sum[4*idx+:4]<=adder sum; carry reg<=adder cout; idx<=idx+1.
  - When idx==NIB-1: cout<=adder cout; go to DONE.
  - Exactly NIB cycles in ADD. in_valid is ignored (not latched).
- DONE:
  - out_valid=1. sum and cout hold stable while out_valid && !out_ready.
  - On out_ready: out_valid<=0; go to IDLE.
  - in_ready stays 0 in DONE; no input is accepted until IDLE.
- Latency: acceptance at cycle T gives out_valid=1 at cycle T+NIB+1 (registered). Minimum issue interval is NIB+2 cycles.
- Arithmetic: unsigned modular. cout is the true carry out of bit WIDTH-1.
- Index counter width is clog2(NIB), minimum 1. The counter never wraps past NIB-1 in ADD.
- out_ready asserted before out_valid has no effect. out_ready held high returns to IDLE the cycle after DONE is entered.
- Wrapper outputs are all registered; the adder path is the only combinational logic.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit): two's-complement signed overflow of the WIDTH-bit add, = carry into MSB XOR carry out of MSB.
  - Registered with cout, reset 0, held stable with sum in DONE.
  - The carry into the MSB is computed from the final nibble's bit-2 carry: a_reg[W-1]^b_reg[W-1]^sum[W-1].
- When undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=16):
- a=16'h1234, b=16'h4321, cin=0, out_ready=1 -> after 4 ADD cycles out_valid=1, sum=16'h5555, cout=0; valid lasts 1 cycle.
- a=16'hFFFF, b=16'h0000, cin=1 -> carry ripples through all nibbles: sum=16'h0000, cout=1; with OVF_EN, ovf=0.
- a=16'h7FFF, b=16'h0001, cin=0 (OVF_EN defined) -> sum=16'h8000, cout=0, ovf=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands toggling -> sum/cout stable, in_ready=0, new operands not latched; out_ready=1 -> IDLE, next operand accepted.
- rst pulsed during the 2nd ADD cycle of a=16'hABCD, b=16'h1111 -> immediately out_valid=0, sum=0, cout=0, busy=0; then in_ready=1 and a fresh add of 16'h0001+16'h0001 gives sum=16'h0002.
- Random back-to-back (1000 ops, random out_ready) -> every result equals {cout,sum}==a+b+cin; in_ready is never high outside IDLE.
